// File: rtl/axi_slave_write_arbiter_if.sv
// Bundle of every master-side and slave-side write channel seen by one
// slave-port write arbiter. The "slave" modport is the arbiter's own view
// (it accepts the masters' requests and drives the slave port); the
// "master" modport is the opposite view used by whatever surrounds it.
interface axi_slave_write_arbiter_if #(
  parameter int MASTER_NUM = 4,
  parameter int W_ID_LEN   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int EXTRA      = $clog2(MASTER_NUM);
  localparam int SID_LEN    = EXTRA + W_ID_LEN;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Master side, packed per master (master i in slice i)
  logic [MASTER_NUM*W_ID_LEN-1:0]   M_AWID;
  logic [MASTER_NUM*ADDR_WIDTH-1:0] M_AWADDR;
  logic [MASTER_NUM*8-1:0]          M_AWLEN;
  logic [MASTER_NUM*3-1:0]          M_AWSIZE;
  logic [MASTER_NUM*2-1:0]          M_AWBURST;
  logic [MASTER_NUM-1:0]            M_AWVALID;
  logic [MASTER_NUM-1:0]            M_AWREADY;
  logic [MASTER_NUM*DATA_WIDTH-1:0] M_WDATA;
  logic [MASTER_NUM*STRB_WIDTH-1:0] M_WSTRB;
  logic [MASTER_NUM-1:0]            M_WLAST;
  logic [MASTER_NUM-1:0]            M_WVALID;
  logic [MASTER_NUM-1:0]            M_WREADY;
  logic [MASTER_NUM*W_ID_LEN-1:0]   M_BID;
  logic [MASTER_NUM*2-1:0]          M_BRESP;
  logic [MASTER_NUM-1:0]            M_BVALID;
  logic [MASTER_NUM-1:0]            M_BREADY;

  // Slave side (ID widened by the master index)
  logic [SID_LEN-1:0]    S_AWID;
  logic [ADDR_WIDTH-1:0] S_AWADDR;
  logic [7:0]            S_AWLEN;
  logic [2:0]            S_AWSIZE;
  logic [1:0]            S_AWBURST;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [DATA_WIDTH-1:0] S_WDATA;
  logic [STRB_WIDTH-1:0] S_WSTRB;
  logic                  S_WLAST;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic [SID_LEN-1:0]    S_BID;
  logic [1:0]            S_BRESP;
  logic                  S_BVALID;
  logic                  S_BREADY;

  modport slave (
    input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
    output M_AWREADY,
    input  M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    output M_WREADY,
    output M_BID, M_BRESP, M_BVALID,
    input  M_BREADY,
    output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    input  S_AWREADY,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    input  S_WREADY,
    input  S_BID, S_BRESP, S_BVALID,
    output S_BREADY
  );

  modport master (
    output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
    input  M_AWREADY,
    output M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    input  M_WREADY,
    input  M_BID, M_BRESP, M_BVALID,
    output M_BREADY,
    input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    output S_AWREADY,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    output S_WREADY,
    output S_BID, S_BRESP, S_BVALID,
    input  S_BREADY
  );
endinterface

// File: rtl/axi_slave_write_arbiter.sv
// Write-path scheduler for one slave port of an AXI4 crossbar.
// Round-robin AW arbitration, W routing locked to the winner until WLAST,
// master index prepended to AWID, B responses routed back by that index.
// Only one write burst is in flight at a time.
module axi_slave_write_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int W_ID_LEN   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic                         ACLK,
  input logic                         ARESET,
  axi_slave_write_arbiter_if.slave    bus
);
  localparam int EXTRA      = $clog2(MASTER_NUM);
  localparam int SID_LEN    = EXTRA + W_ID_LEN;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [EXTRA-1:0] grant_q, grant_d;
  logic [EXTRA-1:0] rr_ptr_q, rr_ptr_d;

  logic [EXTRA-1:0]      arb_pick;
  logic                  arb_found;
  logic [EXTRA:0]        scan_sum;
  logic [MASTER_NUM-1:0] grant_oh;
  logic [EXTRA-1:0]      next_ptr;
  logic                  w_done;

  logic [W_ID_LEN-1:0]   mux_awid;
  logic [ADDR_WIDTH-1:0] mux_awaddr;
  logic [7:0]            mux_awlen;
  logic [2:0]            mux_awsize;
  logic [1:0]            mux_awburst;
  logic                  mux_awvalid;
  logic [DATA_WIDTH-1:0] mux_wdata;
  logic [STRB_WIDTH-1:0] mux_wstrb;
  logic                  mux_wlast;
  logic                  mux_wvalid;

  logic [EXTRA-1:0]      b_idx;
  logic [MASTER_NUM-1:0] b_sel_oh;

  // Round-robin scan: first requesting master at or after rr_ptr, wrapping
  always_comb begin
    arb_pick  = '0;
    arb_found = 1'b0;
    scan_sum  = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      scan_sum  = {1'b0, rr_ptr_q} + (EXTRA+1)'(k);
      scan_sum  = (scan_sum >= (EXTRA+1)'(MASTER_NUM)) ? scan_sum - (EXTRA+1)'(MASTER_NUM) : scan_sum;
      arb_pick  = (!arb_found && bus.M_AWVALID[scan_sum[EXTRA-1:0]]) ? scan_sum[EXTRA-1:0] : arb_pick;
      arb_found = arb_found | bus.M_AWVALID[scan_sum[EXTRA-1:0]];
    end
  end

  // One-hot decode of the registered grant; drives every datapath mux
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      grant_oh[i] = (int'(grant_q) == i);
    end
  end

  // AND-OR select of the granted master's AW and W fields (no X leakage from others)
  always_comb begin
    mux_awid    = '0;
    mux_awaddr  = '0;
    mux_awlen   = '0;
    mux_awsize  = '0;
    mux_awburst = '0;
    mux_awvalid = 1'b0;
    mux_wdata   = '0;
    mux_wstrb   = '0;
    mux_wlast   = 1'b0;
    mux_wvalid  = 1'b0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      mux_awid    = mux_awid    | ({W_ID_LEN{grant_oh[i]}}   & bus.M_AWID[i*W_ID_LEN +: W_ID_LEN]);
      mux_awaddr  = mux_awaddr  | ({ADDR_WIDTH{grant_oh[i]}} & bus.M_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH]);
      mux_awlen   = mux_awlen   | ({8{grant_oh[i]}}          & bus.M_AWLEN[i*8 +: 8]);
      mux_awsize  = mux_awsize  | ({3{grant_oh[i]}}          & bus.M_AWSIZE[i*3 +: 3]);
      mux_awburst = mux_awburst | ({2{grant_oh[i]}}          & bus.M_AWBURST[i*2 +: 2]);
      mux_awvalid = mux_awvalid | (grant_oh[i] & bus.M_AWVALID[i]);
      mux_wdata   = mux_wdata   | ({DATA_WIDTH{grant_oh[i]}} & bus.M_WDATA[i*DATA_WIDTH +: DATA_WIDTH]);
      mux_wstrb   = mux_wstrb   | ({STRB_WIDTH{grant_oh[i]}} & bus.M_WSTRB[i*STRB_WIDTH +: STRB_WIDTH]);
      mux_wlast   = mux_wlast   | (grant_oh[i] & bus.M_WLAST[i]);
      mux_wvalid  = mux_wvalid  | (grant_oh[i] & bus.M_WVALID[i]);
    end
  end

  // Next-state logic: IDLE arbitrates, AW waits for the address handshake, W runs to WLAST
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    next_ptr = (int'(grant_q) == MASTER_NUM - 1) ? '0 : grant_q + EXTRA'(1);
    w_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = arb_found ? ST_AW : ST_IDLE;
        grant_d = arb_found ? arb_pick : grant_q;
      end
      ST_AW: begin
        state_d = (mux_awvalid & bus.S_AWREADY) ? ST_W : ST_AW;
      end
      ST_W: begin
        w_done   = mux_wvalid & bus.S_WREADY & mux_wlast;
        state_d  = w_done ? ST_IDLE : ST_W;
        rr_ptr_d = w_done ? next_ptr : rr_ptr_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler state; reset abandons any burst in progress
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Slave-side channels and master readies, opened only in the matching phase
  always_comb begin
    bus.S_AWID    = '0;
    bus.S_AWADDR  = '0;
    bus.S_AWLEN   = '0;
    bus.S_AWSIZE  = '0;
    bus.S_AWBURST = '0;
    bus.S_AWVALID = 1'b0;
    bus.M_AWREADY = '0;
    bus.S_WDATA   = '0;
    bus.S_WSTRB   = '0;
    bus.S_WLAST   = 1'b0;
    bus.S_WVALID  = 1'b0;
    bus.M_WREADY  = '0;
    case (state_q)
      ST_AW: begin
        bus.S_AWID    = {grant_q, mux_awid};
        bus.S_AWADDR  = mux_awaddr;
        bus.S_AWLEN   = mux_awlen;
        bus.S_AWSIZE  = mux_awsize;
        bus.S_AWBURST = mux_awburst;
        bus.S_AWVALID = mux_awvalid;
        bus.M_AWREADY = grant_oh & {MASTER_NUM{bus.S_AWREADY}};
      end
      ST_W: begin
        bus.S_WDATA  = mux_wdata;
        bus.S_WSTRB  = mux_wstrb;
        bus.S_WLAST  = mux_wlast;
        bus.S_WVALID = mux_wvalid;
        bus.M_WREADY = grant_oh & {MASTER_NUM{bus.S_WREADY}};
      end
      default: begin
        bus.S_AWVALID = 1'b0;
      end
    endcase
  end

  // B return path: decode the master index from the top ID bits, independent of the FSM
  always_comb begin
    b_idx    = bus.S_BID[SID_LEN-1 -: EXTRA];
    b_sel_oh = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      b_sel_oh[i] = (int'(b_idx) == i);
    end
    bus.M_BVALID = b_sel_oh & {MASTER_NUM{bus.S_BVALID}};
    bus.M_BID    = {MASTER_NUM{bus.S_BID[W_ID_LEN-1:0]}};
    bus.M_BRESP  = {MASTER_NUM{bus.S_BRESP}};
    // An index with no master behind it is drained rather than stalling the slave
    bus.S_BREADY = (|b_sel_oh) ? |(bus.M_BREADY & b_sel_oh) : 1'b1;
  end
endmodule

// File: tb/tb_axi_slave_write_arbiter.sv
// Self-checking bench for axi_slave_write_arbiter: a transaction-level model
// (current owner, whether its address is accepted, last finished owner)
// predicts every output each cycle, plus directed scenarios with literal values.
module tb_axi_slave_write_arbiter;
  localparam int N = 4;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi_slave_write_arbiter_if #(.MASTER_NUM(N), .W_ID_LEN(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi_slave_write_arbiter #(.MASTER_NUM(N), .W_ID_LEN(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  // Per-master stimulus
  logic [3:0]  awid    [N];
  logic [31:0] awaddr  [N];
  logic [7:0]  awlen   [N];
  logic [2:0]  awsize  [N];
  logic [1:0]  awburst [N];
  logic [63:0] wdata   [N];
  logic [7:0]  wstrb   [N];
  logic [3:0]  awvalid, wvalid, wlast, m_bready;
  logic        s_awready, s_wready, s_bvalid;
  logic [5:0]  s_bid;
  logic [1:0]  s_bresp;

  int total = 0;
  int bad = 0;
  bit run_cmp = 1'b0;

  // Model: owner of the port (-1 = free), address accepted, last finished owner
  int m_owner = -1;
  bit m_aw_done = 1'b0;
  int m_last = N - 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.M_AWID[i*4 +: 4]     = awid[i];
      bus.M_AWADDR[i*32 +: 32] = awaddr[i];
      bus.M_AWLEN[i*8 +: 8]    = awlen[i];
      bus.M_AWSIZE[i*3 +: 3]   = awsize[i];
      bus.M_AWBURST[i*2 +: 2]  = awburst[i];
      bus.M_WDATA[i*64 +: 64]  = wdata[i];
      bus.M_WSTRB[i*8 +: 8]    = wstrb[i];
    end
    bus.M_AWVALID = awvalid;
    bus.M_WVALID  = wvalid;
    bus.M_WLAST   = wlast;
    bus.M_BREADY  = m_bready;
    bus.S_AWREADY = s_awready;
    bus.S_WREADY  = s_wready;
    bus.S_BVALID  = s_bvalid;
    bus.S_BID     = s_bid;
    bus.S_BRESP   = s_bresp;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Model update on each clock edge, cleared immediately by reset
  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_owner   <= -1;
      m_aw_done <= 1'b0;
      m_last    <= N - 1;
    end else if (m_owner < 0) begin
      if (rr_pick(m_last, awvalid) >= 0) begin
        m_owner   <= rr_pick(m_last, awvalid);
        m_aw_done <= 1'b0;
      end
    end else if (!m_aw_done) begin
      if (awvalid[m_owner] && s_awready) m_aw_done <= 1'b1;
    end else if (wvalid[m_owner] && s_wready && wlast[m_owner]) begin
      m_last  <= m_owner;
      m_owner <= -1;
    end
  end

  task automatic check_outputs();
    int o;
    bit awp, wp;
    logic [1:0] bi;
    o   = m_owner;
    awp = (o >= 0) && !m_aw_done;
    wp  = (o >= 0) && m_aw_done;
    chk("s_awvalid", bus.S_AWVALID, awp ? awvalid[o] : 1'b0);
    chk("m_awready", bus.M_AWREADY, (awp && s_awready) ? (4'b0001 << o) : 4'b0000);
    if (awp && awvalid[o]) begin
      chk("s_awid", bus.S_AWID, {2'(o), awid[o]});
      chk("s_awaddr", bus.S_AWADDR, awaddr[o]);
      chk("s_awlen", bus.S_AWLEN, awlen[o]);
      chk("s_awsize", bus.S_AWSIZE, awsize[o]);
      chk("s_awburst", bus.S_AWBURST, awburst[o]);
    end
    chk("s_wvalid", bus.S_WVALID, wp ? wvalid[o] : 1'b0);
    chk("m_wready", bus.M_WREADY, (wp && s_wready) ? (4'b0001 << o) : 4'b0000);
    if (wp && wvalid[o]) begin
      chk("s_wdata", bus.S_WDATA, wdata[o]);
      chk("s_wstrb", bus.S_WSTRB, wstrb[o]);
      chk("s_wlast", bus.S_WLAST, wlast[o]);
    end
    bi = s_bid[5:4];
    chk("m_bvalid", bus.M_BVALID, s_bvalid ? (4'b0001 << bi) : 4'b0000);
    chk("s_bready", bus.S_BREADY, m_bready[bi]);
    chk("m_bid", bus.M_BID, {4{s_bid[3:0]}});
    chk("m_bresp", bus.M_BRESP, {4{s_bresp}});
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge ACLK) begin
    if (run_cmp) check_outputs();
  end

  task automatic clr_inputs();
    for (int i = 0; i < N; i++) begin
      awid[i] = 4'h0; awaddr[i] = 32'h0; awlen[i] = 8'h0; awsize[i] = 3'h0;
      awburst[i] = 2'h0; wdata[i] = 64'h0; wstrb[i] = 8'h0;
    end
    awvalid = 4'h0; wvalid = 4'h0; wlast = 4'h0; m_bready = 4'h0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = 6'h0; s_bresp = 2'h0;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic smp();
    @(negedge ACLK);
  endtask

  task automatic reset_dut();
    ARESET = 1'b1;
    clr_inputs();
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
  int beat;
  logic [5:0] id_seen;

  initial begin
    // Reset state: requests present but nothing may pass
    clr_inputs();
    awvalid = 4'hF; wvalid = 4'hF; s_awready = 1'b1; s_wready = 1'b1;
    tick();
    tick();
    run_cmp = 1'b1;
    smp();
    chk("rst_s_awvalid", bus.S_AWVALID, 1'b0);
    chk("rst_s_wvalid", bus.S_WVALID, 1'b0);
    chk("rst_m_awready", bus.M_AWREADY, 4'h0);
    chk("rst_m_wready", bus.M_WREADY, 4'h0);

    // 1: single request from master 2, 4-beat burst
    reset_dut();
    awvalid[2] = 1'b1; awid[2] = 4'h5; awlen[2] = 8'd3; awaddr[2] = 32'h0000_2000; s_awready = 1'b1;
    smp();
    chk("t1_latency_idle", bus.S_AWVALID, 1'b0);
    tick();
    smp();
    chk("t1_awvalid", bus.S_AWVALID, 1'b1);
    chk("t1_awid", bus.S_AWID, 6'h25);
    chk("t1_awlen", bus.S_AWLEN, 8'd3);
    tick();
    awvalid[2] = 1'b0; wvalid[2] = 1'b1; s_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wdata[2] = 64'hBEEF_0000_0000_0000 + 64'(b);
      wlast[2] = (b == 3);
      smp();
      chk("t1_wdata", bus.S_WDATA, 64'hBEEF_0000_0000_0000 + 64'(b));
      chk("t1_wready", bus.M_WREADY, 4'b0100);
      tick();
    end
    wvalid[2] = 1'b0; wlast[2] = 1'b0;
    smp();
    chk("t1_idle_after", {bus.S_AWVALID, bus.S_WVALID, bus.M_WREADY}, 6'h0);

    // 2: fairness with all masters requesting single-beat bursts
    reset_dut();
    awvalid = 4'hF; wvalid = 4'hF; wlast = 4'hF; s_awready = 1'b1; s_wready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      smp();
      id_seen = bus.S_AWID;
      case (k % 3)
        0: chk("t2_bubble", {bus.S_AWVALID, bus.S_WVALID}, 2'b00);
        1: chk("t2_grant", {bus.S_AWVALID, id_seen[5:4]}, {1'b1, 2'(exp_order[k/3])});
        default: chk("t2_wready", bus.M_WREADY, 4'b0001 << exp_order[k/3]);
      endcase
      tick();
    end

    // 3: AW backpressure, then toggling W backpressure
    reset_dut();
    awvalid[1] = 1'b1; awaddr[1] = 32'h1000_0040; awlen[1] = 8'd2;
    smp();
    tick();
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("t3_awaddr_hold", bus.S_AWADDR, 32'h1000_0040);
      chk("t3_awready_low", bus.M_AWREADY, 4'h0);
      tick();
    end
    s_awready = 1'b1;
    smp();
    chk("t3_awready", bus.M_AWREADY, 4'b0010);
    tick();
    awvalid[1] = 1'b0; s_awready = 1'b0; wvalid[1] = 1'b1;
    beat = 0;
    for (int c = 0; c < 12 && beat < 3; c++) begin
      s_wready = (c % 2 == 1);
      wdata[1] = 64'hC0DE_0000_0000_0000 + 64'(beat);
      wlast[1] = (beat == 2);
      smp();
      chk("t3_wready", bus.M_WREADY, s_wready ? 4'b0010 : 4'b0000);
      chk("t3_wdata", bus.S_WDATA, 64'hC0DE_0000_0000_0000 + 64'(beat));
      if (s_wready) beat++;
      tick();
    end
    wvalid[1] = 1'b0; wlast[1] = 1'b0; s_wready = 1'b0; awvalid[0] = 1'b1; s_awready = 1'b1;
    smp();
    chk("t3_idle_gap", bus.S_AWVALID, 1'b0);
    tick();
    smp();
    chk("t3_next_grant", {bus.S_AWVALID, bus.S_AWID}, {1'b1, 6'h00});

    // 4: B routing by the top ID bits
    reset_dut();
    s_bvalid = 1'b1; s_bid = 6'h3A; s_bresp = 2'b10; m_bready = 4'b1000;
    #1;
    chk("t4_bvalid", bus.M_BVALID, 4'b1000);
    chk("t4_bid", bus.M_BID, 16'hAAAA);
    chk("t4_bready_hi", bus.S_BREADY, 1'b1);
    m_bready = 4'b0111;
    #1;
    chk("t4_bready_lo", bus.S_BREADY, 1'b0);

    // 5: reset in the middle of a burst
    reset_dut();
    awvalid[1] = 1'b1; s_awready = 1'b1; wvalid[1] = 1'b1; wlast[1] = 1'b1; s_wready = 1'b1;
    tick();
    tick();
    awvalid[1] = 1'b0;
    tick();
    wvalid[1] = 1'b0; wlast[1] = 1'b0;
    awvalid[3] = 1'b1; awlen[3] = 8'd3; wvalid[3] = 1'b1;
    tick();
    tick();
    awvalid[3] = 1'b0;
    tick();
    tick();
    awvalid = 4'b1001;
    #2;
    ARESET = 1'b1;
    #1;
    chk("t5_rst_clear", {bus.S_AWVALID, bus.S_WVALID, bus.M_AWREADY, bus.M_WREADY}, 10'h0);
    #3;
    ARESET = 1'b0; wvalid = 4'h0;
    tick();
    smp();
    id_seen = bus.S_AWID;
    chk("t5_fresh_grant", {bus.S_AWVALID, id_seen[5:4]}, 3'b100);

    // 6: random traffic against the model
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        awid[i] = 4'($urandom); awaddr[i] = $urandom; awlen[i] = 8'($urandom);
        awsize[i] = 3'($urandom); awburst[i] = 2'($urandom);
        wdata[i] = {$urandom, $urandom}; wstrb[i] = 8'($urandom);
      end
      awvalid = 4'($urandom);
      wvalid = 4'($urandom) | 4'($urandom);
      wlast = 4'($urandom) & 4'($urandom);
      s_awready = 1'($urandom);
      s_wready = ($urandom_range(0, 2) != 0);
      s_bvalid = 1'($urandom); s_bid = 6'($urandom); s_bresp = 2'($urandom);
      m_bready = 4'($urandom);
      tick();
    end

    smp();
    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
